// File: rtl/arbiter_game_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : arbiter_game_multi_if
// Brief    : Player-facing bus of the N-player reaction arbiter game: button
//            requests in, LEDs / GO / match-over / packed scores out.
// Revision : 1.0 - initial release
// ============================================================================
interface arbiter_game_multi_if #(
    parameter int NUM_PLAYERS = 4,
    parameter int SCORE_W     = 3
);
    logic [NUM_PLAYERS-1:0]         req_in;
    logic [NUM_PLAYERS-1:0]         leds_out;
    logic                           go_out;
    logic                           match_over_out;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores_out;

    // Environment side: drives buttons, watches the game outputs
    modport master (
        output req_in,
        input  leds_out,
        input  go_out,
        input  match_over_out,
        input  scores_out
    );

    // Game side
    modport slave (
        input  req_in,
        output leds_out,
        output go_out,
        output match_over_out,
        output scores_out
    );
endinterface
`default_nettype wire

// File: rtl/arbiter_game_multi.sv
`default_nettype none
// ============================================================================
// Module   : arbiter_game_multi
// Brief    : N-player reaction game. Countdown, GO window, first eligible press
//            wins (rotating priority on ties), per-player saturating scores,
//            match ends when the round winner reaches WIN_SCORE.
//            Optional false-start lockout: define ARBITER_FALSE_START_EN.
// Revision : 1.0 - initial release
// ============================================================================
module arbiter_game_multi #(
    parameter int NUM_PLAYERS      = 4,
    parameter int CLOCK_FREQ       = 1000,
    parameter int PRESCALER_COUNT  = 250,
    parameter int COUNTDOWN_TICKS  = 4,
    parameter int GO_TIMEOUT_TICKS = 8,
    parameter int RESULT_TICKS     = 4,
    parameter int SCORE_W          = 3,
    parameter int WIN_SCORE        = 3
) (
    input  wire logic          clk,
    input  wire logic          rst_in,
    arbiter_game_multi_if.slave bus
);
    localparam int IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int PW    = $clog2(PRESCALER_COUNT);
    localparam int MAXT0 = (COUNTDOWN_TICKS > GO_TIMEOUT_TICKS) ? COUNTDOWN_TICKS : GO_TIMEOUT_TICKS;
    localparam int MAXT  = (MAXT0 > RESULT_TICKS) ? MAXT0 : RESULT_TICKS;
    localparam int TW    = $clog2(MAXT + 1);

    // Reject unusable configurations at elaboration time
    if (NUM_PLAYERS < 2 || NUM_PLAYERS > 8 || PRESCALER_COUNT < 2 || CLOCK_FREQ < 1 ||
        WIN_SCORE < 1 || WIN_SCORE > (1 << SCORE_W) - 1) begin : g_bad_params
        $error("arbiter_game_multi: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_COUNTDOWN  = 3'd1,
        S_GO         = 3'd2,
        S_RESULT     = 3'd3,
        S_MATCH_OVER = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_PLAYERS-1:0]   sync1_q, sync2_q, sync3_q, press_q;
    logic [PW-1:0]            presc_q;
    logic [TW-1:0]            tidx_q;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [IDX_W-1:0]         win_q, win_d;
    logic                     winv_q, winv_d;
    logic [NUM_PLAYERS-1:0]   result_q, result_d;
    logic [SCORE_W-1:0]       score_q [NUM_PLAYERS];

    logic                     w_tick;
    logic [NUM_PLAYERS-1:0]   w_elig;
    logic                     w_all_locked;
    logic [NUM_PLAYERS-1:0]   w_lock_leds;
    logic                     w_found;
    logic [IDX_W-1:0]         w_win;
    logic [IDX_W:0]           w_cand;
    logic                     w_score_inc;

    assign w_tick = (presc_q == PW'(PRESCALER_COUNT - 1));

    // Button synchronizer followed by a registered rising-edge detector
    always_ff @(posedge clk) begin
        if (rst_in) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            press_q <= '0;
        end else begin
            sync1_q <= bus.req_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            press_q <= sync2_q & ~sync3_q;
        end
    end

`ifdef ARBITER_FALSE_START_EN
    logic [NUM_PLAYERS-1:0] lockout_q;

    // False starters are remembered until the game returns to IDLE
    always_ff @(posedge clk) begin
        if (rst_in) begin
            lockout_q <= '0;
        end else if (state_d == S_IDLE) begin
            lockout_q <= '0;
        end else if (state_q == S_COUNTDOWN) begin
            lockout_q <= lockout_q | press_q;
        end
    end

    assign w_elig       = press_q & ~lockout_q;
    assign w_all_locked = &lockout_q;
    assign w_lock_leds  = lockout_q;
`else
    assign w_elig       = press_q;
    assign w_all_locked = 1'b0;
    assign w_lock_leds  = '0;
`endif

    // Rotating-priority search starting at ptr_q
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            w_cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(NUM_PLAYERS)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_PLAYERS);
            end
            if (!w_found && w_elig[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[IDX_W-1:0];
            end
        end
    end

    // Game state register and per-round bookkeeping
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            winv_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            winv_q   <= winv_d;
            result_q <= result_d;
        end
    end

    // Next-state logic; a press on the timeout tick still wins
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        winv_d      = winv_q;
        result_d    = result_q;
        w_score_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|press_q) state_d = S_COUNTDOWN;
            end
            S_COUNTDOWN: begin
                if (w_tick && tidx_q == TW'(COUNTDOWN_TICKS - 1)) state_d = S_GO;
            end
            S_GO: begin
                if (w_found) begin
                    state_d     = S_RESULT;
                    win_d       = w_win;
                    winv_d      = 1'b1;
                    result_d    = {{(NUM_PLAYERS-1){1'b0}}, 1'b1} << w_win;
                    ptr_d       = (w_win == IDX_W'(NUM_PLAYERS - 1)) ? '0 : w_win + IDX_W'(1);
                    w_score_inc = 1'b1;
                end else if (w_all_locked || (w_tick && tidx_q == TW'(GO_TIMEOUT_TICKS - 1))) begin
                    state_d  = S_RESULT;
                    winv_d   = 1'b0;
                    result_d = '0;
                end
            end
            S_RESULT: begin
                if (w_tick && tidx_q == TW'(RESULT_TICKS - 1)) begin
                    if (winv_q && score_q[win_q] == SCORE_W'(WIN_SCORE)) state_d = S_MATCH_OVER;
                    else                                                 state_d = S_IDLE;
                end
            end
            S_MATCH_OVER: state_d = S_MATCH_OVER;
            default:      state_d = S_IDLE;
        endcase
    end

    // Prescaler and tick index restart on every state change
    always_ff @(posedge clk) begin
        if (rst_in || state_d != state_q) begin
            presc_q <= '0;
            tidx_q  <= '0;
        end else if (w_tick) begin
            presc_q <= '0;
            tidx_q  <= tidx_q + TW'(1);
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Saturating per-player scores
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (rst_in) begin
                score_q[i] <= '0;
            end else if (w_score_inc && w_win == IDX_W'(i) && score_q[i] != '1) begin
                score_q[i] <= score_q[i] + SCORE_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_scores
        assign bus.scores_out[g*SCORE_W +: SCORE_W] = score_q[g];
    end

    // LED / status decode from the current state
    always_comb begin
        bus.leds_out       = '0;
        bus.go_out         = 1'b0;
        bus.match_over_out = 1'b0;
        case (state_q)
            S_COUNTDOWN:  bus.leds_out = (tidx_q[0] ? '0 : '1) | w_lock_leds;
            S_GO:         bus.go_out   = 1'b1;
            S_RESULT:     bus.leds_out = result_q;
            S_MATCH_OVER: begin
                bus.leds_out       = result_q;
                bus.match_over_out = 1'b1;
            end
            default:      bus.leds_out = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: doc/arbiter_game_multi.md
Name: arbiter_game_multi

Overview:
- N-player successor of the two-player reaction arbiter game; sits under the TinyTapeout top wrapper, driven from io_in, driving io_out LEDs.
- Runs a countdown, opens a GO window, and awards the round to the first eligible player press.
- Ties are broken by rotating priority.
- Keeps per-player scores; declares a match winner at WIN_SCORE.

Parameters:
- NUM_PLAYERS, 4, number of request inputs / players (2..8)
- CLOCK_FREQ, 1000, clk frequency in Hz (informational)
- PRESCALER_COUNT, 250, clk cycles per game tick (>=2)
- COUNTDOWN_TICKS, 4, ticks spent in COUNTDOWN
- GO_TIMEOUT_TICKS, 8, ticks in GO before the round is voided
- RESULT_TICKS, 4, ticks spent showing the round result
- SCORE_W, 3, score counter width per player
- WIN_SCORE, 3, score that ends the match (1..2^SCORE_W-1)

Ports:
- clk  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- req_in  in  NUM_PLAYERS  asynchronous player buttons, active-high
- leds_out  out  NUM_PLAYERS  player LEDs
- go_out  out  1  high while the GO window is open
- match_over_out  out  1  high once a player reaches WIN_SCORE
- scores_out  out  NUM_PLAYERS*SCORE_W  player i score at bits [i*SCORE_W +: SCORE_W]

Behaviour:
- Interface: one clock clk; reset rst_in is synchronous and active-high. Everything else is synchronous to clk.
- Reset values: all outputs 0, state IDLE, scores 0, priority pointer 0, prescaler 0.
- Input path:
  - Each req_in bit passes a 2-flop synchronizer, then a registered rising-edge detector.
  - A pin rising at cycle t yields press[i]=1 during cycle t+3, for one cycle.
  - Holding a button produces no further presses.
- Prescaler:
  - Counts 0..PRESCALER_COUNT-1; tick=1 when count==PRESCALER_COUNT-1.
  - Cleared to 0 on every state transition, so a state lasting K ticks lasts exactly K*PRESCALER_COUNT cycles.
- IDLE:
  - leds_out=0, go_out=0.
  - Any press -> COUNTDOWN next cycle. That press is not a game press.
- COUNTDOWN:
  - leds_out = all ones while the tick index is even, all zeros while odd (blink), starting with ones.
  - After COUNTDOWN_TICKS ticks -> GO.
  - Presses are ignored (see optional feature).
- GO:
  - go_out=1, leds_out=0.
  - On the first cycle any eligible press occurs, a winner is chosen:
    - Search indices ptr, ptr+1, ... mod N; the first asserted one wins.
    - Winner w: score[w] += 1 (saturating at 2^SCORE_W-1).
    - ptr <= (w+1) mod N.
    - Next cycle -> RESULT with latched leds = one-hot(w).
  - No eligible press within GO_TIMEOUT_TICKS ticks -> RESULT, no winner, leds=0, scores and ptr unchanged.
  - A press in the same cycle as the timeout tick wins (press has priority over timeout).
- RESULT:
  - go_out=0; leds_out holds the latched result for RESULT_TICKS ticks.
  - Then -> MATCH_OVER if the winner's score == WIN_SCORE, else -> IDLE.
  - Presses are ignored.
- MATCH_OVER:
  - match_over_out=1; leds_out = one-hot(match winner) steady; scores frozen.
  - Exits only via rst_in.
- Scores update in the cycle after the winning press; scores_out is registered.
- rst_in asserted in any state: the next cycle is at reset values. Scores clear, and presses in flight in the synchronizer are discarded (sync flops reset to 0).
- Several simultaneous presses in GO: exactly one winner, determined by ptr. Example: N=4, ptr=2, presses {0,3} -> 3 wins.

Optional Feature:
- Macro: ARBITER_FALSE_START_EN.
- Defined:
  - A press during COUNTDOWN sets lockout[i]; locked players are ineligible in GO, and their LED is forced on during COUNTDOWN.
  - If all NUM_PLAYERS are locked out when GO is entered, go directly to RESULT with no winner (GO lasts 1 cycle, go_out pulses once).
  - lockout clears on entry to IDLE and on reset.
- Undefined: COUNTDOWN presses are discarded and every player is always eligible. No lockout flops are built.

Test Plan (N=4, PRESCALER_COUNT=4, COUNTDOWN_TICKS=2, GO_TIMEOUT_TICKS=3, RESULT_TICKS=2, WIN_SCORE=2):
- Reset behaviour: reset, then a single press of player 0 -> COUNTDOWN lasts 8 cycles with leds 1111 then 0000. GO: player 1 rises -> 3 cycles later winner; next cycle leds=0010, score1=1, ptr=2; RESULT lasts 8 cycles; then IDLE.
- Tie / rotating priority: players 0 and 3 pressed in the same cycle with ptr=2 -> player 3 wins, ptr=0. Repeat with ptr=0 -> player 0 wins.
- Timeout: no press in GO -> go_out high exactly 12 cycles, RESULT with leds=0000, scores unchanged.
- Match end: player 2 wins two rounds -> match_over_out=1, leds=0100 steady; further presses change nothing; rst_in clears everything in 1 cycle.
- Reset mid-round: rst_in pulsed during GO with a press 1 cycle earlier -> outputs zero next cycle, no score increments afterwards.
- Optional feature (ARBITER_FALSE_START_EN): player 1 presses in COUNTDOWN, players 1 and 2 press together in GO with ptr=1 -> player 2 wins. All four locked out -> go_out pulses 1 cycle, no winner.
